mem_arbiter: RTL and testbench

- Shares the single-port core memory (1024 x 16-bit words, 1-cycle synchronous read) between two requesters: the evaluator core and the garbage collector / heap walker.
- Sits between core/gc memory buses and the memory instance.
- Fixed priority to core, with a starvation guard for gc.
- Lock mechanism makes cons allocation (read free pointer, write cell, write pointer) atomic.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_starve_counter.sv | 46 ++++
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the core/gc memory arbiter.
//   arb_state_t : arbitration FSM states (open, locked to core, locked to gc)
//   arb_owner_t : which requester a pending read belongs to
//   MemAddrWidth / MemSize : geometry of the single-port core memory
//   sat_inc16   : saturating 16-bit increment used by the optional statistics
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Lisp word payload width; memory words carry one extra tag bit.
    localparam int WordSize     = 15;
    localparam int MemDataWidth = WordSize + 1;
    localparam int MemAddrWidth = 10;
    localparam int MemSize      = 1024;

    typedef enum logic [1:0] {
        ArbOpen     = 2'd0,
        ArbLockCore = 2'd1,
        ArbLockGc   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OwnerCore = 1'b0,
        OwnerGc   = 1'b1
    } arb_owner_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
// Counts consecutive cycles in which the gc requester was denied. Saturates at
// MaxWait; at_max tells the arbiter that gc must win the next open arbitration.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : gc requested and was not granted this cycle
//   clr       : gc was granted this cycle (takes priority over inc)
//   at_max    : count has reached MaxWait
// -----------------------------------------------------------------------------
module starve_counter #(
    parameter int MaxWait = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CntWidth = (MaxWait < 1) ? 1 : $clog2(MaxWait + 1);
    localparam logic [CntWidth-1:0] MaxVal = CntWidth'(MaxWait);

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MaxVal);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous-read memory between the evaluator core
// and the garbage collector. Core has fixed priority; gc is forced through
// after MaxWait consecutive denied cycles. A requester may lock the memory
// across several accesses (e.g. cons allocation) by asserting *_lock.
//
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   core_req/we/lock/addr/wdata    : core access request
//   core_gnt                       : access accepted this cycle (combinational)
//   core_rvalid, core_rdata        : read data, one cycle after a read grant
//   gc_*                           : same set for the garbage collector
//   mem_en/we/addr/wdata           : memory command, driven from the winner
//   mem_rdata                      : memory read data (valid cycle after read)
//
// Optional feature (macro ARB_STATS_EN): adds saturating 16-bit counters
//   stat_core_grants, stat_gc_grants, stat_gc_stall (denied gc cycles).
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AddrWidth = MemAddrWidth,
    parameter int DataWidth = MemDataWidth,
    parameter int MaxWait   = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 core_req,
    input  logic                 core_we,
    input  logic                 core_lock,
    input  logic [AddrWidth-1:0] core_addr,
    input  logic [DataWidth-1:0] core_wdata,
    output logic                 core_gnt,
    output logic                 core_rvalid,
    output logic [DataWidth-1:0] core_rdata,

    input  logic                 gc_req,
    input  logic                 gc_we,
    input  logic                 gc_lock,
    input  logic [AddrWidth-1:0] gc_addr,
    input  logic [DataWidth-1:0] gc_wdata,
    output logic                 gc_gnt,
    output logic                 gc_rvalid,
    output logic [DataWidth-1:0] gc_rdata,

    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]          stat_core_grants,
    output logic [15:0]          stat_gc_grants,
    output logic [15:0]          stat_gc_stall
`endif
);

    arb_state_t state_q, state_d;
    arb_owner_t rsel_q, rsel_d;
    logic       rd_pending_q, rd_pending_d;
    logic       wait_at_max;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
    starve_counter #(
        .MaxWait (MaxWait)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (gc_req && !gc_gnt),
        .clr    (gc_gnt),
        .at_max (wait_at_max)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ArbOpen;
            rsel_q       <= OwnerCore;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsel_q       <= rsel_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: arbitration, memory mux, read return
    // ------------------------------------------------------------------
    always_comb begin
        core_gnt  = 1'b0;
        gc_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Grants are held off while reset is asserted so the memory sees no
        // command during reset even if requesters are still driving.
        if (!rst) begin
            case (state_q)
                ArbOpen: begin
                    gc_gnt   = gc_req && (!core_req || wait_at_max);
                    core_gnt = core_req && !gc_gnt;
                end
                // A lock holder excludes the other side even when the
                // starvation guard has saturated.
                ArbLockCore: core_gnt = core_req;
                ArbLockGc:   gc_gnt   = gc_req;
                default: begin
                    core_gnt = 1'b0;
                    gc_gnt   = 1'b0;
                end
            endcase
        end

        if (gc_gnt) begin
            mem_en    = 1'b1;
            mem_we    = gc_we;
            mem_addr  = gc_addr;
            mem_wdata = gc_wdata;
        end else if (core_gnt) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end

        // Read data is shared; rvalid tells each side whether it is theirs.
        core_rvalid = rd_pending_q && (rsel_q == OwnerCore);
        gc_rvalid   = rd_pending_q && (rsel_q == OwnerGc);
        core_rdata  = rd_pending_q ? mem_rdata : '0;
        gc_rdata    = rd_pending_q ? mem_rdata : '0;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rsel_d       = rsel_q;
        rd_pending_d = (core_gnt && !core_we) || (gc_gnt && !gc_we);

        if (gc_gnt) begin
            rsel_d = OwnerGc;
        end else if (core_gnt) begin
            rsel_d = OwnerCore;
        end

        case (state_q)
            ArbOpen: begin
                if (gc_gnt && gc_lock) begin
                    state_d = ArbLockGc;
                end else if (core_gnt && core_lock) begin
                    state_d = ArbLockCore;
                end
            end
            // Lock is released only by a granted access with lock=0;
            // an idle owner keeps it indefinitely.
            ArbLockCore: begin
                if (core_gnt && !core_lock) begin
                    state_d = ArbOpen;
                end
            end
            ArbLockGc: begin
                if (gc_gnt && !gc_lock) begin
                    state_d = ArbOpen;
                end
            end
            default: state_d = ArbOpen;
        endcase
    end

`ifdef ARB_STATS_EN
    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
    logic [15:0] stat_core_q, stat_core_d;
    logic [15:0] stat_gc_q,   stat_gc_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_core_d  = core_gnt ? sat_inc16(stat_core_q) : stat_core_q;
        stat_gc_d    = gc_gnt   ? sat_inc16(stat_gc_q)   : stat_gc_q;
        stat_stall_d = (gc_req && !gc_gnt) ? sat_inc16(stat_stall_q) : stat_stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_core_q  <= '0;
            stat_gc_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_core_q  <= stat_core_d;
            stat_gc_q    <= stat_gc_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_core_grants = stat_core_q;
    assign stat_gc_grants   = stat_gc_q;
    assign stat_gc_stall    = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed, table-driven bench for mem_arbiter with a behavioural 1024x16
// synchronous-read memory attached. Define ARB_STATS_EN to also cover the
// statistics counters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        core_req = 0, core_we = 0, core_lock = 0;
    logic [9:0]  core_addr = 0;
    logic [15:0] core_wdata = 0;
    logic        core_gnt, core_rvalid;
    logic [15:0] core_rdata;

    logic        gc_req = 0, gc_we = 0, gc_lock = 0;
    logic [9:0]  gc_addr = 0;
    logic [15:0] gc_wdata = 0;
    logic        gc_gnt, gc_rvalid;
    logic [15:0] gc_rdata;

    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 0;

`ifdef ARB_STATS_EN
    logic [15:0] stat_core_grants, stat_gc_grants, stat_gc_stall;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AddrWidth(10), .DataWidth(16), .MaxWait(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_lock  (core_lock),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .gc_req     (gc_req),
        .gc_we      (gc_we),
        .gc_lock    (gc_lock),
        .gc_addr    (gc_addr),
        .gc_wdata   (gc_wdata),
        .gc_gnt     (gc_gnt),
        .gc_rvalid  (gc_rvalid),
        .gc_rdata   (gc_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_core_grants(stat_core_grants),
        .stat_gc_grants  (stat_gc_grants),
        .stat_gc_stall   (stat_gc_stall)
`endif
    );

    // Initial memory contents: address 1 holds 0x2A2A, others a pattern.
    function automatic logic [15:0] iv(input int a);
        return (a == 1) ? 16'h2A2A : (16'hA500 ^ 16'(a));
    endfunction

    logic [15:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = iv(i);
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        c_req, c_we, c_lock;
        logic [9:0]  c_addr;
        logic [15:0] c_wd;
        logic        g_req, g_we, g_lock;
        logic [9:0]  g_addr;
        logic [15:0] g_wd;
        logic        e_cg, e_gg, e_crv, e_grv;
        logic [15:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, cw, cl, input logic [9:0] ca, input logic [15:0] cd,
        input logic gr, gw, gl, input logic [9:0] ga, input logic [15:0] gd,
        input logic ecg, egg, ecrv, egrv, input logic [15:0] erd);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_lock = cl; v.c_addr = ca; v.c_wd = cd;
        v.g_req = gr; v.g_we = gw; v.g_lock = gl; v.g_addr = ga; v.g_wd = gd;
        v.e_cg = ecg; v.e_gg = egg; v.e_crv = ecrv; v.e_grv = egrv; v.e_rd = erd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        core_req = v.c_req; core_we = v.c_we; core_lock = v.c_lock;
        core_addr = v.c_addr; core_wdata = v.c_wd;
        gc_req = v.g_req; gc_we = v.g_we; gc_lock = v.g_lock;
        gc_addr = v.g_addr; gc_wdata = v.g_wd;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_lock = 0; core_addr = 0; core_wdata = 0;
        gc_req = 0; gc_we = 0; gc_lock = 0; gc_addr = 0; gc_wdata = 0;
    endtask

    vec_t vecs[$];

    initial begin
        // core read, then lock sequence, lock held across saturated guard,
        // forced gc win, back-to-back reads, gc lock excluding core.
        vecs.push_back(mk(1,0,0,10'h001,0,      0,0,0,0,0,          1,0,0,0,16'h0));     // 0
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,0,0,          0,0,1,0,16'h2A2A));  // 1
        vecs.push_back(mk(1,1,1,10'h010,16'h1234, 1,0,0,10'h010,0,  1,0,0,0,16'h0));     // 2
        vecs.push_back(mk(1,0,1,10'h011,0,      1,0,0,10'h010,0,    1,0,0,0,16'h0));     // 3
        vecs.push_back(mk(1,1,0,10'h012,16'h5555, 1,0,0,10'h010,0,  1,0,1,0,iv('h11)));  // 4
        vecs.push_back(mk(0,0,0,0,0,            1,0,0,10'h010,0,    0,1,0,0,16'h0));     // 5
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,0,0,          0,0,0,1,16'h1234));  // 6
        vecs.push_back(mk(1,0,1,10'h012,0,      1,0,0,10'h000,0,    1,0,0,0,16'h0));     // 7
        vecs.push_back(mk(0,0,0,0,0,            1,0,0,10'h000,0,    0,0,1,0,16'h5555));  // 8
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0,0,0,0,0,        1,0,0,10'h000,0,    0,0,0,0,16'h0));     // 9-16
        vecs.push_back(mk(1,0,0,10'h003,0,      1,0,0,10'h000,0,    1,0,0,0,16'h0));     // 17
        vecs.push_back(mk(1,0,0,10'h004,0,      1,0,0,10'h000,0,    0,1,1,0,iv(3)));     // 18
        vecs.push_back(mk(1,0,0,10'h004,0,      0,0,0,0,0,          1,0,0,1,iv(0)));     // 19
        vecs.push_back(mk(1,0,0,10'h000,0,      0,0,0,0,0,          1,0,1,0,iv(4)));     // 20
        vecs.push_back(mk(1,0,0,10'h001,0,      0,0,0,0,0,          1,0,1,0,iv(0)));     // 21
        vecs.push_back(mk(1,0,0,10'h002,0,      0,0,0,0,0,          1,0,1,0,iv(1)));     // 22
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,0,0,          0,0,1,0,iv(2)));     // 23
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,0,0,          0,0,0,0,16'h0));     // 24
        vecs.push_back(mk(0,0,0,0,0,            1,1,1,10'h020,16'hBEEF, 0,1,0,0,16'h0)); // 25
        vecs.push_back(mk(1,0,0,10'h020,0,      0,0,0,0,0,          0,0,0,0,16'h0));     // 26
        vecs.push_back(mk(1,0,0,10'h020,0,      1,0,0,10'h020,0,    0,1,0,0,16'h0));     // 27
        vecs.push_back(mk(1,0,0,10'h020,0,      0,0,0,0,0,          1,0,0,1,16'hBEEF));  // 28
        vecs.push_back(mk(0,0,0,0,0,            0,0,0,0,0,          0,0,1,0,16'hBEEF));  // 29

        // ---------------- reset state ----------------
        #2;
        check("rst_core_gnt", core_gnt, 0);
        check("rst_gc_gnt", gc_gnt, 0);
        check("rst_core_rvalid", core_rvalid, 0);
        check("rst_gc_rvalid", gc_rvalid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_core_rdata", core_rdata, 0);
        @(negedge clk);
        rst = 0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [9:0]  ea;
            logic [15:0] ed;
            logic        ew;
            v = vecs[i];
            @(posedge clk);
            #1;
            drive(v);
            @(negedge clk);
            ea = v.e_gg ? v.g_addr : (v.e_cg ? v.c_addr : 10'h0);
            ew = v.e_gg ? v.g_we   : (v.e_cg ? v.c_we   : 1'b0);
            ed = v.e_gg ? v.g_wd   : (v.e_cg ? v.c_wd   : 16'h0);
            check($sformatf("v%0d_core_gnt", i), core_gnt, v.e_cg);
            check($sformatf("v%0d_gc_gnt", i), gc_gnt, v.e_gg);
            check($sformatf("v%0d_core_rvalid", i), core_rvalid, v.e_crv);
            check($sformatf("v%0d_gc_rvalid", i), gc_rvalid, v.e_grv);
            check($sformatf("v%0d_mem_en", i), mem_en, v.e_cg | v.e_gg);
            if (v.e_cg | v.e_gg) begin
                check($sformatf("v%0d_mem_we", i), mem_we, ew);
                check($sformatf("v%0d_mem_addr", i), mem_addr, ea);
                if (ew) check($sformatf("v%0d_mem_wdata", i), mem_wdata, ed);
            end
            if (v.e_crv) check($sformatf("v%0d_core_rdata", i), core_rdata, v.e_rd);
            if (v.e_grv) check($sformatf("v%0d_gc_rdata", i), gc_rdata, v.e_rd);
            $display("vec %0d: core_gnt=%0d gc_gnt=%0d core_rvalid=%0d gc_rvalid=%0d rdata=%h",
                     i, core_gnt, gc_gnt, core_rvalid, gc_rvalid, core_rdata);
        end

        // ---------------- starvation guard, both requesting ----------------
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            core_req = 1; core_we = 0; core_lock = 0; core_addr = 10'(i % 8);
            gc_req = 1; gc_we = 0; gc_lock = 0; gc_addr = 10'h100;
            @(negedge clk);
            check($sformatf("starve%0d_core_gnt", i), core_gnt, (i % 9) != 8);
            check($sformatf("starve%0d_gc_gnt", i), gc_gnt, (i % 9) == 8);
`ifdef ARB_STATS_EN
            if (i == 18) begin
                check("stat_core_grants", stat_core_grants, 16);
                check("stat_gc_grants", stat_gc_grants, 2);
                check("stat_gc_stall", stat_gc_stall, 16);
            end
`endif
            $display("starve %0d: core_gnt=%0d gc_gnt=%0d", i, core_gnt, gc_gnt);
        end

        // ---------------- reset mid-operation ----------------
        @(posedge clk);
        #1;
        idle_inputs();
        gc_req = 1; gc_we = 0; gc_lock = 1; gc_addr = 10'h001;
        @(negedge clk);
        check("midrst_gc_lock_gnt", gc_gnt, 1);
        @(posedge clk);
        #1;
        idle_inputs();
        check("midrst_gc_rvalid_pending", gc_rvalid, 1);
        rst = 1;
        #1;
        check("midrst_gc_rvalid_dropped", gc_rvalid, 0);
        check("midrst_mem_en", mem_en, 0);
        @(negedge clk);
        rst = 0;
        core_req = 1; core_addr = 10'h005;
        #1;
        check("midrst_core_not_locked_out", core_gnt, 1);
        $display("reset mid-op: core_gnt=%0d after reset release", core_gnt);
        @(posedge clk);
        #1;
        idle_inputs();
        gc_req = 1; gc_addr = 10'h006;
        @(negedge clk);
        check("midrst_gc_gnt", gc_gnt, 1);
        check("midrst_core_rvalid", core_rvalid, 1);
        check("midrst_core_rdata", core_rdata, iv(5));
        $display("reset mid-op: gc_gnt=%0d core_rvalid=%0d rdata=%h", gc_gnt, core_rvalid, core_rdata);
        @(posedge clk);
        #1;
        idle_inputs();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
